// File: rtl/set_compare_pkg.sv
// Shared opcode encodings and immediate sign-extension for the set-compare unit.
// Optional SET_COMPARE_FLAGS_EN exposes raw compare flags from set_compare_pipe.
package set_compare_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLT   = 3'd0;
    localparam op_t OP_SLTU  = 3'd1;
    localparam op_t OP_SLTI  = 3'd2;
    localparam op_t OP_SLTIU = 3'd3;
    localparam op_t OP_SEQ   = 3'd4;
    localparam op_t OP_SNE   = 3'd5;
    localparam op_t OP_SGE   = 3'd6;
    localparam op_t OP_SGEU  = 3'd7;

    localparam int SEXT_MAXW = 64;

    // Left-align the field, then arithmetic-shift back; caller truncates to WIDTH.
    function automatic logic [SEXT_MAXW-1:0] sext(
        input logic [SEXT_MAXW-1:0] v,
        input int                   iw
    );
        logic signed [SEXT_MAXW-1:0] t;
        t = $signed(v << (SEXT_MAXW - iw));
        return t >>> (SEXT_MAXW - iw);
    endfunction

    function automatic logic is_imm(input op_t op);
        return (op == OP_SLTI) || (op == OP_SLTIU);
    endfunction

endpackage

// File: rtl/set_compare_core.sv
// Combinational compare: (a, b, op) -> set bit plus raw lt_s / lt_u / eq flags.
// Shared with the branch unit, so the flags are always produced.
module set_compare_core
    import set_compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic             bit_o,
    output logic             lt_s_o,
    output logic             lt_u_o,
    output logic             eq_o
);

    always_comb begin
        lt_s_o = $signed(a_i) < $signed(b_i);
        lt_u_o = a_i < b_i;
        eq_o   = a_i == b_i;
        bit_o  = 1'b0;
        unique case (op_i)
            OP_SLT:   bit_o = lt_s_o;
            OP_SLTU:  bit_o = lt_u_o;
            OP_SLTI:  bit_o = lt_s_o;
            OP_SLTIU: bit_o = lt_u_o;
            OP_SEQ:   bit_o = eq_o;
            OP_SNE:   bit_o = !eq_o;
            OP_SGE:   bit_o = !lt_s_o;
            OP_SGEU:  bit_o = !lt_u_o;
        endcase
    end

endmodule

// File: rtl/set_compare_pipe.sv
// Two-stage set-on-compare execution unit with valid/ready on both sides.
// Define SET_COMPARE_FLAGS_EN to add out_lt_s / out_lt_u / out_eq outputs.
module set_compare_pipe
    import set_compare_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 6,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [IMM_WIDTH-1:0] in_imm,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [TAG_WIDTH-1:0] out_tag
`ifdef SET_COMPARE_FLAGS_EN
    ,
    output logic                 out_lt_s,
    output logic                 out_lt_u,
    output logic                 out_eq
`endif
);

    logic                 s1_valid_q, s1_valid_d;
    op_t                  s1_op_q,    s1_op_d;
    logic [WIDTH-1:0]     s1_a_q,     s1_a_d;
    logic [WIDTH-1:0]     s1_b_q,     s1_b_d;
    logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_res_q,   s2_res_d;
    logic [TAG_WIDTH-1:0] s2_tag_q,   s2_tag_d;

    logic s1_adv;
    logic s2_adv;
    logic [WIDTH-1:0] b_sel;

    logic cmp_bit;
    logic cmp_lt_s;
    logic cmp_lt_u;
    logic cmp_eq;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    assign b_sel = is_imm(op_t'(in_op))
                 ? WIDTH'(sext(SEXT_MAXW'(in_imm), IMM_WIDTH))
                 : in_b;

    set_compare_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .op_i   (s1_op_q),
        .bit_o  (cmp_bit),
        .lt_s_o (cmp_lt_s),
        .lt_u_o (cmp_lt_u),
        .eq_o   (cmp_eq)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = op_t'(in_op);
                s1_a_d   = in_a;
                s1_b_d   = b_sel;
                s1_tag_d = in_tag;
            end
        end
        // A flush wins over an input transfer in the same cycle.
        if (flush) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_tag_d   = s2_tag_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = cmp_bit;
                s2_tag_d = s1_tag_q;
            end
        end
        if (flush) begin
            s2_valid_d = 1'b0;
            s2_res_d   = 1'b0;
            s2_tag_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_SLT;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = {{(WIDTH-1){1'b0}}, s2_res_q};
    assign out_tag    = s2_tag_q;

`ifdef SET_COMPARE_FLAGS_EN
    logic [2:0] s2_flags_q, s2_flags_d;

    always_comb begin
        s2_flags_d = s2_flags_q;
        if (s2_adv && s1_valid_q) begin
            s2_flags_d = {cmp_lt_s, cmp_lt_u, cmp_eq};
        end
        if (flush) begin
            s2_flags_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_flags_q <= '0;
        end else begin
            s2_flags_q <= s2_flags_d;
        end
    end

    assign out_lt_s = s2_flags_q[2];
    assign out_lt_u = s2_flags_q[1];
    assign out_eq   = s2_flags_q[0];
`else
    // Flags stay available on the core for the branch unit only.
    logic unused_flags;
    assign unused_flags = cmp_lt_s ^ cmp_lt_u ^ cmp_eq;
`endif

endmodule
